// File: rtl/gps_axi_pkg.sv
// Shared constants, FSM state types and helpers
// for the GPS AXI4-Lite register window.
package gps_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ADDR_LSB = 2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gps_axi_lite_slave_if.sv
// AXI4-Lite bus bundle between the system master
// and the GPS register window.
interface gps_axi_lite_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT,
    output S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB,
    output S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT,
    output S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP,
    input  S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT,
    input  S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB,
    input  S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT,
    input  S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP,
    output S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

// File: rtl/gps_axi_regfile.sv
// Byte-strobed register array feeding the GPS core,
// with a one-cycle write pulse per register.
module gps_axi_regfile
  import gps_axi_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = idx_w(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [IDX_W-1:0]           widx,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic [IDX_W-1:0]           ridx,
  output logic [DATA_W-1:0]          rdata,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Bytewise register update on a committed write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < STRB_W; b++)
        if (wstrb[b])
          regs[widx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // Pulse the written register's flag, even with no strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wr <= '0;
    end else begin
      reg_wr <= '0;
      if (we)
        reg_wr[widx] <= 1'b1;
    end
  end

  assign rdata = regs[ridx];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: rtl/gps_axi_lite_slave.sv
// AXI4-Lite responder for the GPS register window.
// Optional SLVERR decode: `define GPS_AXI_SLVERR_EN
module gps_axi_lite_slave
  import gps_axi_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 4,
  parameter int ADDR_LSB = gps_axi_pkg::ADDR_LSB
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  gps_axi_lite_slave_if.slave        s_axi,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr
);

  localparam int IDX_W  = idx_w(NUM_REGS);
  localparam int STRB_W = DATA_W / 8;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic              awready, wready, bvalid;
  logic              commit, aw_take, w_take;
  logic              arready, rvalid, ar_hs;
  logic [ADDR_W-1:0] aw_addr_q, wr_addr;
  logic [DATA_W-1:0] w_data_q, wr_data;
  logic [STRB_W-1:0] w_strb_q, wr_strb;
  logic [1:0]        bresp_q, rresp_q;
  logic [DATA_W-1:0] rdata_q, rf_rdata;
  logic              wr_err, rd_err;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              unused_bits;

  // Write state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  // Write next-state, readies and commit decode
  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    commit  = 1'b0;
    aw_take = 1'b0;
    w_take  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (s_axi.S_AXI_AWVALID &&
            s_axi.S_AXI_WVALID) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else if (s_axi.S_AXI_AWVALID) begin
          aw_take = 1'b1;
          w_next  = W_HAVE_ADDR;
        end else if (s_axi.S_AXI_WVALID) begin
          w_take = 1'b1;
          w_next = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        wready = 1'b1;
        if (s_axi.S_AXI_WVALID) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        awready = 1'b1;
        if (s_axi.S_AXI_AWVALID) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (s_axi.S_AXI_BREADY)
          w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign wr_addr = (w_state == W_HAVE_ADDR) ?
                   aw_addr_q : s_axi.S_AXI_AWADDR;
  assign wr_data = (w_state == W_HAVE_DATA) ?
                   w_data_q : s_axi.S_AXI_WDATA;
  assign wr_strb = (w_state == W_HAVE_DATA) ?
                   w_strb_q : s_axi.S_AXI_WSTRB;
  assign wr_idx  = wr_addr[ADDR_LSB +: IDX_W];
  assign rd_idx  = s_axi.S_AXI_ARADDR[ADDR_LSB +: IDX_W];

`ifdef GPS_AXI_SLVERR_EN
  assign wr_err =
    |wr_addr[ADDR_W-1:ADDR_LSB+IDX_W];
  assign rd_err =
    |s_axi.S_AXI_ARADDR[ADDR_W-1:ADDR_LSB+IDX_W];
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  // Hold the half of a write that arrives first; latch response
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_take)
        aw_addr_q <= s_axi.S_AXI_AWADDR;
      if (w_take) begin
        w_data_q <= s_axi.S_AXI_WDATA;
        w_strb_q <= s_axi.S_AXI_WSTRB;
      end
      if (commit)
        bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Read state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  // Read next-state and handshake decode
  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (s_axi.S_AXI_ARVALID)
          r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (s_axi.S_AXI_RREADY)
          r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_hs = arready & s_axi.S_AXI_ARVALID;

  // Capture read data before any same-edge write lands
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_err ? '0 : rf_rdata;
      rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  gps_axi_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .we     (commit & ~wr_err),
    .widx   (wr_idx),
    .wdata  (wr_data),
    .wstrb  (wr_strb),
    .ridx   (rd_idx),
    .rdata  (rf_rdata),
    .reg_q  (reg_q),
    .reg_wr (reg_wr)
  );

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

  assign unused_bits = ^{s_axi.S_AXI_AWPROT,
                         s_axi.S_AXI_ARPROT,
                         wr_addr,
                         s_axi.S_AXI_ARADDR};

endmodule
